// File: rtl/seq_det_frame_ctrl.sv
// Frame controller for the serial sequence detector: takes words over valid/ready,
// serialises them onto det_x, and counts det_z matches within a latency-aligned window.
module seq_det_frame_ctrl #(
   parameter int WORD_W    = 8,
   parameter int LEN_W     = 4,
   parameter int CNT_W     = 8,
   parameter int DET_LAT   = 1,
   parameter int MSB_FIRST = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [LEN_W-1:0]  frame_len,
   input  logic              in_valid,
   input  logic [WORD_W-1:0] in_data,
   output logic              in_ready,
   output logic              det_rst,
   output logic              det_x,
   input  logic              det_z,
   output logic              busy,
   output logic              done,
   output logic [CNT_W-1:0]  match_cnt,
   output logic              sat,
   output logic              err
);

   localparam int BW = (WORD_W > 1) ? $clog2(WORD_W) : 1;
   localparam int DW = (DET_LAT > 1) ? $clog2(DET_LAT) : 1;

   typedef enum logic [2:0] {IDLE, ARM, RUN, DRAIN, DONE} state_t;

   state_t              state, state_nxt;
   logic [LEN_W-1:0]    len_q;
   logic [LEN_W-1:0]    words_acc;
   logic [WORD_W-1:0]   shreg;
   logic [WORD_W-1:0]   hold_q;
   logic                hold_full;
   logic [BW-1:0]       bit_cnt;
   logic [DW-1:0]       drain_cnt;
   logic [DET_LAT-1:0]  flag_d;

   logic accept;
   logic last_bit;
   logic words_left;

   assign accept     = in_valid & in_ready;
   assign last_bit   = (bit_cnt == BW'(WORD_W - 1));
   assign words_left = hold_full | (words_acc != len_q);

   // State register
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Next state and state-decoded outputs; in_ready depends only on registered state
   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      busy      = 1'b1;
      done      = 1'b0;
      det_x     = 1'b0;
      case (state)
         IDLE: begin
            busy = 1'b0;
            if (start) state_nxt = (frame_len == '0) ? DONE : ARM;
         end
         ARM: begin
            in_ready = 1'b1;
            if (in_valid) state_nxt = RUN;
         end
         RUN: begin
            in_ready = ~hold_full & (words_acc < len_q);
            det_x    = (MSB_FIRST != 0) ? shreg[WORD_W-1] : shreg[0];
            if (last_bit) begin
               if (!words_left)            state_nxt = DRAIN;
               else if (hold_full | accept) state_nxt = RUN;
               else                         state_nxt = DONE;
            end
         end
         DRAIN: begin
            if (drain_cnt == DW'(DET_LAT - 1)) state_nxt = DONE;
         end
         DONE: begin
            done      = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign det_rst = rst | ((state != RUN) & (state != DRAIN));

   // Datapath: shift register with one-word prefetch, frame bookkeeping and match counting
   always_ff @(posedge clk) begin
      if (rst) begin
         len_q     <= '0;
         words_acc <= '0;
         shreg     <= '0;
         hold_q    <= '0;
         hold_full <= 1'b0;
         bit_cnt   <= '0;
         drain_cnt <= '0;
         flag_d    <= '0;
         match_cnt <= '0;
         sat       <= 1'b0;
         err       <= 1'b0;
      end else begin
         flag_d <= DET_LAT'({flag_d, (state == RUN)});

         if ((state == IDLE) && start) begin
            len_q     <= frame_len;
            words_acc <= '0;
            hold_full <= 1'b0;
            match_cnt <= '0;
            sat       <= 1'b0;
            err       <= 1'b0;
         end else if (det_z && flag_d[DET_LAT-1]) begin
            if (match_cnt == {CNT_W{1'b1}}) sat       <= 1'b1;
            else                            match_cnt <= match_cnt + CNT_W'(1);
         end

         case (state)
            ARM: begin
               if (accept) begin
                  shreg     <= in_data;
                  bit_cnt   <= '0;
                  words_acc <= words_acc + LEN_W'(1);
               end
            end
            RUN: begin
               drain_cnt <= '0;
               if (accept) words_acc <= words_acc + LEN_W'(1);
               if (last_bit) begin
                  bit_cnt <= '0;
                  if (hold_full) begin
                     shreg     <= hold_q;
                     hold_full <= 1'b0;
                  end else if (accept) begin
                     shreg <= in_data;
                  end else if (words_left) begin
                     err <= 1'b1;
                  end
               end else begin
                  bit_cnt <= bit_cnt + BW'(1);
                  shreg   <= (MSB_FIRST != 0) ? (shreg << 1) : (shreg >> 1);
                  if (accept) begin
                     hold_q    <= in_data;
                     hold_full <= 1'b1;
                  end
               end
            end
            DRAIN: drain_cnt <= drain_cnt + DW'(1);
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_seq_det_frame_ctrl.sv
// Directed self-checking bench for seq_det_frame_ctrl; a behavioural "10101" overlapping
// detector with one cycle of latency stands in for seq_det.
module tb_seq_det_frame_ctrl;

   logic       clk;
   logic       rst;
   logic       start;
   logic [3:0] frame_len;
   logic       in_valid;
   logic [7:0] in_data;

   logic       in_ready0, det_rst0, det_x0, det_z0, busy0, done0, sat0, err0;
   logic [7:0] match_cnt0;
   logic       in_ready1, det_rst1, det_x1, det_z1, busy1, done1, sat1, err1;
   logic [1:0] match_cnt1;

   logic [4:0] hist0, hist1;

   int   checks;
   int   passes;

   int          doneAt, firstBit, nBits;
   bit          seenDone, readySeen;
   logic [31:0] bits;
   logic        errD, satD, sat1D, detRstD, done1D;
   logic [7:0]  cntD;
   logic [1:0]  cnt1D;

   seq_det_frame_ctrl dut0 (
      .clk(clk), .rst(rst), .start(start), .frame_len(frame_len),
      .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready0),
      .det_rst(det_rst0), .det_x(det_x0), .det_z(det_z0), .busy(busy0),
      .done(done0), .match_cnt(match_cnt0), .sat(sat0), .err(err0)
   );

   seq_det_frame_ctrl #(.CNT_W(2)) dut1 (
      .clk(clk), .rst(rst), .start(start), .frame_len(frame_len),
      .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready1),
      .det_rst(det_rst1), .det_x(det_x1), .det_z(det_z1), .busy(busy1),
      .done(done1), .match_cnt(match_cnt1), .sat(sat1), .err(err1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Detector stand-ins: z answers the bit on det_x one clock later
   always @(posedge clk) begin
      if (det_rst0) begin
         hist0  <= '0;
         det_z0 <= 1'b0;
      end else begin
         hist0  <= {hist0[3:0], det_x0};
         det_z0 <= ({hist0[3:0], det_x0} == 5'b10101);
      end
   end

   always @(posedge clk) begin
      if (det_rst1) begin
         hist1  <= '0;
         det_z1 <= 1'b0;
      end else begin
         hist1  <= {hist1[3:0], det_x1};
         det_z1 <= ({hist1[3:0], det_x1} == 5'b10101);
      end
   end

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got === exp) passes++;
      else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   // Runs one frame from IDLE and records what the DUTs showed up to the done pulse
   task automatic applyStimulus(input logic [3:0] len, input logic [7:0] w0, input logic [7:0] w1,
                                input bit withhold, input bit midStart);
      int  cyc;
      int  wordIdx;
      bit  fire;
      seenDone  = 0;
      readySeen = 0;
      firstBit  = -1;
      nBits     = 0;
      bits      = '0;
      doneAt    = -1;
      wordIdx   = 0;
      cyc       = 0;
      start     = 1'b1;
      frame_len = len;
      tick();
      start     = 1'b0;
      while (cyc < 300 && !seenDone) begin
         if (!det_rst0 && nBits < 32) begin
            if (firstBit < 0) firstBit = cyc;
            bits  = {bits[30:0], det_x0};
            nBits = nBits + 1;
         end
         if (in_ready0) readySeen = 1;
         if (done0) begin
            seenDone = 1;
            doneAt   = (firstBit < 0) ? cyc : (cyc - firstBit + 1);
            errD     = err0;
            cntD     = match_cnt0;
            satD     = sat0;
            detRstD  = det_rst0;
            cnt1D    = match_cnt1;
            sat1D    = sat1;
            done1D   = done1;
         end
         start    = (midStart && cyc == 5);
         in_valid = (wordIdx < int'(len)) && !(withhold && wordIdx == 1);
         in_data  = (wordIdx == 0) ? w0 : w1;
         fire     = in_valid && in_ready0;
         tick();
         cyc = cyc + 1;
         if (fire) wordIdx = wordIdx + 1;
      end
      start    = 1'b0;
      in_valid = 1'b0;
      checkOutput("frame_timeout", 32'(seenDone), 32'd1);
      checkOutput("done_one_cycle", 32'(done0), 32'd0);
   endtask

   initial begin
      int doneSeenRst;
      checks    = 0;
      passes    = 0;
      rst       = 1'b1;
      start     = 1'b0;
      frame_len = '0;
      in_valid  = 1'b0;
      in_data   = '0;
      repeat (3) tick();
      rst = 1'b0;
      checkOutput("rst_in_ready", 32'(in_ready0), 32'd0);
      checkOutput("rst_det_rst", 32'(det_rst0), 32'd1);
      checkOutput("rst_det_x", 32'(det_x0), 32'd0);
      checkOutput("rst_busy", 32'(busy0), 32'd0);
      checkOutput("rst_done", 32'(done0), 32'd0);
      checkOutput("rst_match_cnt", 32'(match_cnt0), 32'd0);
      checkOutput("rst_sat", 32'(sat0), 32'd0);
      checkOutput("rst_err", 32'(err0), 32'd0);
      tick();

      // Single word A8: 10101000 then one drain zero, one match
      $display("[TB] frame_len=1 word A8");
      applyStimulus(4'd1, 8'hA8, 8'h00, 1'b0, 1'b0);
      checkOutput("t1_bits", bits, 32'h150);
      checkOutput("t1_nbits", 32'(nBits), 32'd9);
      checkOutput("t1_done_latency", 32'(doneAt), 32'd10);
      checkOutput("t1_match_cnt", 32'(cntD), 32'd1);
      checkOutput("t1_err", 32'(errD), 32'd0);
      checkOutput("t1_idle_after", 32'(busy0), 32'd0);
      tick();

      // Two AA words back to back with a stray start mid-frame
      $display("[TB] frame_len=2 words AA AA");
      applyStimulus(4'd2, 8'hAA, 8'hAA, 1'b0, 1'b1);
      checkOutput("t2_bits", bits, 32'h15554);
      checkOutput("t2_nbits", 32'(nBits), 32'd17);
      checkOutput("t2_done_latency", 32'(doneAt), 32'd18);
      checkOutput("t2_match_cnt", 32'(cntD), 32'd6);
      checkOutput("t2_sat", 32'(satD), 32'd0);
      checkOutput("t2_err", 32'(errD), 32'd0);
      checkOutput("t4_done_w2", 32'(done1D), 32'd1);
      checkOutput("t4_match_cnt_w2", 32'(cnt1D), 32'd3);
      checkOutput("t4_sat_w2", 32'(sat1D), 32'd1);
      tick();
      checkOutput("t5_mid_start_ignored", 32'(busy0), 32'd0);

      // Second word withheld: underrun after word 1
      $display("[TB] frame_len=2 underrun");
      applyStimulus(4'd2, 8'hA8, 8'hAA, 1'b1, 1'b0);
      checkOutput("t3_err", 32'(errD), 32'd1);
      checkOutput("t3_det_rst_done", 32'(detRstD), 32'd1);
      checkOutput("t3_match_cnt", 32'(cntD), 32'd1);
      checkOutput("t3_bits", bits, 32'hA8);
      checkOutput("t3_nbits", 32'(nBits), 32'd8);
      checkOutput("t3_done_latency", 32'(doneAt), 32'd9);
      tick();

      // Empty frame
      $display("[TB] frame_len=0");
      applyStimulus(4'd0, 8'hAA, 8'hAA, 1'b0, 1'b0);
      checkOutput("t5_done_next", 32'(doneAt), 32'd0);
      checkOutput("t5_match_cnt", 32'(cntD), 32'd0);
      checkOutput("t5_err", 32'(errD), 32'd0);
      checkOutput("t5_ready_seen", 32'(readySeen), 32'd0);
      tick();

      // Reset in the middle of RUN
      $display("[TB] reset mid-frame");
      start     = 1'b1;
      frame_len = 4'd1;
      tick();
      start    = 1'b0;
      in_valid = 1'b1;
      in_data  = 8'hFF;
      tick();
      in_valid = 1'b0;
      tick();
      tick();
      checkOutput("t6_running", 32'({busy0, det_rst0}), 32'b10);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      checkOutput("t6_busy", 32'(busy0), 32'd0);
      checkOutput("t6_det_rst", 32'(det_rst0), 32'd1);
      checkOutput("t6_in_ready", 32'(in_ready0), 32'd0);
      checkOutput("t6_match_cnt", 32'(match_cnt0), 32'd0);
      doneSeenRst = 0;
      for (int i = 0; i < 12; i++) begin
         if (done0) doneSeenRst++;
         tick();
      end
      checkOutput("t6_no_done", 32'(doneSeenRst), 32'd0);
      applyStimulus(4'd1, 8'hA8, 8'h00, 1'b0, 1'b0);
      checkOutput("t6_after_match_cnt", 32'(cntD), 32'd1);
      checkOutput("t6_after_err", 32'(errD), 32'd0);
      checkOutput("t6_after_latency", 32'(doneAt), 32'd10);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
